// File: rtl/aer_tx_sequencer.sv
// ---------------------------------------------------------------------------
// aer_tx_sequencer
//
// Transmit-side sequencer for the AER link. Spike vectors from the neuron
// array are OR-merged into a pending register. Pending events are drained
// one at a time, highest index first, and each one is presented as an
// address on a four-phase req/ack handshake to the receiver.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        asynchronous, active-high; returns every register to idle
//   spike_in     spike vector, one bit per source
//   spike_valid  spike_in is merged into pending on an edge where this is high
//   ack          receiver acknowledge (four-phase)
//   req          request; addr is valid while high
//   addr         index of the event being sent, all-ones when idle
//   busy         high whenever the sequencer is not idle
//   pending      registered pending spike vector
//   event_count  completed handshakes, wraps modulo 2**COUNT_WIDTH
// ---------------------------------------------------------------------------
module aer_tx_sequencer #(
  parameter int VECTOR_WIDTH = 5,
  parameter int ADDR_WIDTH   = 4,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [VECTOR_WIDTH-1:0] spike_in,
  input  logic                    spike_valid,
  input  logic                    ack,
  output logic                    req,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    busy,
  output logic [VECTOR_WIDTH-1:0] pending,
  output logic [COUNT_WIDTH-1:0]  event_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // All-ones is never a valid source index, so it marks "no event".
  localparam logic [ADDR_WIDTH-1:0]  ADDR_NONE = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  logic [1:0]              state_q, state_d;
  logic                    req_q, req_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    busy_q, busy_d;
  logic [VECTOR_WIDTH-1:0] pending_q, pending_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;

  logic                    pend_any;
  logic [ADDR_WIDTH-1:0]   sel_idx;
  logic                    ack_clear;
  logic [VECTOR_WIDTH-1:0] clr_mask;
  logic [VECTOR_WIDTH-1:0] merge_vec;

  // -------------------------------------------------------------------------
  // Priority select: highest set bit of the registered pending vector. The
  // ascending loop lets later (higher) bits overwrite lower ones. The result
  // is only consumed when pend_any is high.
  // -------------------------------------------------------------------------
  assign pend_any = |pending_q;

  always_comb begin
    sel_idx = ADDR_NONE;
    for (int i = 0; i < VECTOR_WIDTH; i++) begin
      if (pending_q[i]) begin
        sel_idx = ADDR_WIDTH'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Clear mask: one-hot of the address being acknowledged on this edge.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < VECTOR_WIDTH; gi++) begin : g_clr
    assign clr_mask[gi] = ack_clear && (addr_q == ADDR_WIDTH'(gi));
  end

  assign merge_vec = spike_valid ? spike_in : '0;

  // The merge is applied after the clear so a spike re-arriving on the bit
  // being acknowledged survives and is sent again later.
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | merge_vec;
  end

  // -------------------------------------------------------------------------
  // Handshake sequencing
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    count_d   = count_q;
    ack_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A stale ack holds us here until the receiver releases it.
        if (pend_any && !ack) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          addr_d  = sel_idx;
        end
      end

      ST_REQ: begin
        // addr is frozen here even if a higher-index spike arrives.
        if (ack) begin
          state_d   = ST_RELEASE;
          req_d     = 1'b0;
          ack_clear = 1'b1;
          count_d   = count_q + COUNT_ONE;
        end
      end

      ST_RELEASE: begin
        // pending_q already excludes the acknowledged bit at this point, so
        // the next selection can go straight back to REQ.
        if (!ack) begin
          if (pend_any) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            addr_d  = sel_idx;
          end else begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            addr_d  = ADDR_NONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        addr_d  = ADDR_NONE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      addr_q    <= ADDR_NONE;
      busy_q    <= 1'b0;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign req         = req_q;
  assign addr        = addr_q;
  assign busy        = busy_q;
  assign pending     = pending_q;
  assign event_count = count_q;

endmodule
